// File: rtl/select_strobe_pkg.sv
// -----------------------------------------------------------------------------
// select_strobe_pkg
//
// Shared types, default parameters and helpers for the select_strobe block.
//
// Contents:
//   SEL_W_DEF / LEN_W_DEF : default index and strobe-length widths
//   MAX_N                 : widest select vector the decoder helper supports
//   state_t               : strobe FSM state encoding (IDLE, STROBE, GAP)
//   onehot_n()            : active-low one-cold decoder
//
// Configuration macro used by the top: SELECT_STROBE_ABORT_EN
// -----------------------------------------------------------------------------
package select_strobe_pkg;

   localparam int SEL_W_DEF = 3;
   localparam int LEN_W_DEF = 4;

   // The decoder works on a fixed-width vector.  Callers keep the low
   // 2**SEL_W bits.  This supports SEL_W up to 8.
   localparam int MAX_N = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      GAP    = 2'd2
   } state_t;

   // Active-low one-cold decode: bit idx is 0 and every other bit is 1.
   // An out-of-range index gives all ones, so no line is selected.
   function automatic logic [MAX_N-1:0] onehot_n(input int unsigned idx);
      logic [MAX_N-1:0] v;
      v = '1;
      if (idx < MAX_N) begin
         v[idx[7:0]] = 1'b0;
      end
      return v;
   endfunction

endpackage : select_strobe_pkg

// File: rtl/select_strobe_timer.sv
// -----------------------------------------------------------------------------
// strobe_timer
//
// Loadable down-counter that measures the strobe length.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset; clears the count to 0
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one on the next edge; the count stops at 0
//   count    : current count
//   zero     : count == 0
// -----------------------------------------------------------------------------
module strobe_timer
   import select_strobe_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic [LEN_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - LEN_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule : strobe_timer

// File: rtl/select_strobe.sv
// -----------------------------------------------------------------------------
// select_strobe
//
// Registered active-low select-strobe generator.  An accepted request latches
// an index, a strobe length and a scan flag.  The block then drives the
// matching active-low select line for the programmed number of clocks.  In
// scan mode it steps through every higher index.  Each strobe is followed by
// a one-cycle all-high gap.  Scan mode never wraps.
//
// Parameters:
//   SEL_W : index width; N = 2**SEL_W select lines
//   LEN_W : strobe-length field width
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request; sampled only in IDLE
//   sel       : starting index, latched on an accepted start
//   pulse_len : strobe length in clocks, latched on an accepted start;
//               a value of 0 gives a length of 1
//   scan      : latched on an accepted start; 1 = step sel..N-1
//   abort     : (SELECT_STROBE_ABORT_EN only) stop the current request
//               without a done pulse
//   out_n     : active-low select lines; at most one bit is low
//   busy      : high from the first strobe cycle to the last strobe cycle
//   done      : one-cycle completion pulse
//   state_dbg : current FSM state, for observation only
//
// Handshake: start is a request with no ready signal.  The block accepts it
// in any cycle where it is in IDLE.  It ignores start in every other cycle.
// The IDLE cycle that carries done also accepts a new request.
//
// Every output comes straight from a register.  No input reaches an output
// without passing through a register.
//
// Optional feature macro: SELECT_STROBE_ABORT_EN
// -----------------------------------------------------------------------------
module select_strobe
   import select_strobe_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   parameter int LEN_W = LEN_W_DEF
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SEL_W-1:0]      sel,
   input  logic [LEN_W-1:0]      pulse_len,
   input  logic                  scan,
`ifdef SELECT_STROBE_ABORT_EN
   input  logic                  abort,
`endif
   output logic [(2**SEL_W)-1:0] out_n,
   output logic                  busy,
   output logic                  done,
   output state_t                state_dbg
);

   localparam int N = 2**SEL_W;

   state_t           state;
   logic [SEL_W-1:0] idx;
   logic [LEN_W-1:0] len;
   logic             scan_q;

   logic [LEN_W-1:0] eff_len;
   logic [SEL_W-1:0] idx_inc;
   logic             last_idx;
   logic             abort_hit;

   logic             tmr_load;
   logic [LEN_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic [LEN_W-1:0] tmr_count;
   logic             tmr_zero;

   logic [MAX_N-1:0] dec_sel_w;
   logic [MAX_N-1:0] dec_inc_w;

   // A length of 0 runs as 1.  This way every accepted request makes a
   // visible strobe.
   assign eff_len  = (pulse_len == '0) ? LEN_W'(1) : pulse_len;
   assign idx_inc  = idx + SEL_W'(1);
   assign last_idx = (idx == SEL_W'(N - 1));

`ifdef SELECT_STROBE_ABORT_EN
   // abort only acts in STROBE or GAP.  The IDLE branch never looks at it.
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Decode the next index ahead of time.  This lets out_n be loaded on the
   // same edge that enters STROBE.
   assign dec_sel_w = onehot_n(32'(sel));
   assign dec_inc_w = onehot_n(32'(idx_inc));

   // The counter loads len-1 on each edge that enters STROBE.  It reaches 0
   // in the last strobe cycle.
   assign tmr_load     = ((state == IDLE) && start) ||
                         ((state == GAP) && !abort_hit);
   assign tmr_load_val = (state == IDLE) ? (eff_len - LEN_W'(1))
                                         : (len - LEN_W'(1));
   assign tmr_dec      = (state == STROBE) && !tmr_zero;

   strobe_timer #(
      .LEN_W (LEN_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   // Single FSM process.  The registered outputs are assigned together with
   // the state transition that produces them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         len    <= '0;
         scan_q <= 1'b0;
         out_n  <= '1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx    <= sel;
                  len    <= eff_len;
                  scan_q <= scan;
                  out_n  <= dec_sel_w[N-1:0];
                  busy   <= 1'b1;
                  state  <= STROBE;
               end
            end

            STROBE: begin
               if (abort_hit) begin
                  out_n <= '1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tmr_zero) begin
                  out_n <= '1;
                  if (scan_q && !last_idx) begin
                     // busy stays high through the gap.
                     state <= GAP;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            GAP: begin
               if (abort_hit) begin
                  out_n <= '1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx   <= idx_inc;
                  out_n <= dec_inc_w[N-1:0];
                  state <= STROBE;
               end
            end

            default: begin
               out_n <= '1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule : select_strobe

// File: tb/tb_select_strobe.sv
// -----------------------------------------------------------------------------
// tb_select_strobe
//
// Directed bench for select_strobe with the default parameters (SEL_W = 3,
// LEN_W = 4, N = 8).  Inputs change on the falling edge.  Outputs are sampled
// on the falling edge of each cycle, so a sample taken after the k-th rising
// edge shows cycle k of the request.
// -----------------------------------------------------------------------------
module tb_select_strobe;
   import select_strobe_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] sel;
   logic [3:0] pulse_len;
   logic       scan;
`ifdef SELECT_STROBE_ABORT_EN
   logic       abort;
`endif
   logic [7:0] out_n;
   logic       busy;
   logic       done;
   state_t     state_dbg;

   int vec_count = 0;
   int err_count = 0;

   select_strobe #(
      .SEL_W (3),
      .LEN_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sel       (sel),
      .pulse_len (pulse_len),
      .scan      (scan),
`ifdef SELECT_STROBE_ABORT_EN
      .abort     (abort),
`endif
      .out_n     (out_n),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle: past a rising edge, then to the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      // Outputs held during power-on reset.
      repeat (2) @(negedge clk);
      vec_count++;
      if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
         err_count++;
         $display("FAIL reset_init: out_n=%h busy=%b done=%b state=%0d want FF/0/0/IDLE",
                  out_n, busy, done, state_dbg);
      end
      rst_n = 1'b1;
      tick();
      vec_count++;
      if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         err_count++;
         $display("FAIL reset_idle: out_n=%h busy=%b done=%b want FF/0/0", out_n, busy, done);
      end

      // Start a long strobe, then reset it in the middle.
      sel = 3'd5; pulse_len = 4'd8; scan = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      vec_count++;
      if (out_n !== 8'hDF || busy !== 1'b1) begin
         err_count++;
         $display("FAIL reset_pre: out_n=%h busy=%b want DF/1", out_n, busy);
      end
      // Assert reset between edges; the check comes before any rising edge.
      #2 rst_n = 1'b0;
      #1;
      vec_count++;
      if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         err_count++;
         $display("FAIL reset_async: out_n=%h busy=%b done=%b want FF/0/0", out_n, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vec_count++;
         if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
            err_count++;
            $display("FAIL reset_after c%0d: out_n=%h busy=%b done=%b want FF/0/0 IDLE",
                     c, out_n, busy, done);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] eo [1:5];
      logic       eb [1:5];
      logic       ed [1:5];
      eo = '{8'hFB, 8'hFB, 8'hFB, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      sel = 3'd2; pulse_len = 4'd3; scan = 1'b0; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         // Change the inputs after acceptance; the latched values must hold.
         start = 1'b0; sel = 3'd6; pulse_len = 4'd15; scan = 1'b1;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL single c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

   task automatic test_zero_len();
      logic [7:0] eo [1:3];
      logic       eb [1:3];
      logic       ed [1:3];
      eo = '{8'h7F, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b0, 1'b0};
      ed = '{1'b0, 1'b1, 1'b0};
      sel = 3'd7; pulse_len = 4'd0; scan = 1'b0; start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         start = 1'b0;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL zero_len c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

   task automatic test_scan();
      logic [7:0] eo [1:11];
      logic       eb [1:11];
      logic       ed [1:11];
      eo = '{8'hDF, 8'hDF, 8'hFF, 8'hBF, 8'hBF, 8'hFF, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      sel = 3'd5; pulse_len = 4'd2; scan = 1'b1; start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         start = 1'b0;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL scan c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

   task automatic test_scan_last();
      // A scan that starts at index N-1 makes a single strobe.
      logic [7:0] eo [1:3];
      logic       eb [1:3];
      logic       ed [1:3];
      eo = '{8'h7F, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b0, 1'b0};
      ed = '{1'b0, 1'b1, 1'b0};
      sel = 3'd7; pulse_len = 4'd1; scan = 1'b1; start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         start = 1'b0;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL scan_last c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] eo [1:7];
      logic       eb [1:7];
      logic       ed [1:7];
      eo = '{8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      sel = 3'd1; pulse_len = 4'd4; scan = 1'b0; start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         // Pulse start for one cycle in the middle of the strobe.
         start = (c == 2);
         if (c == 2) sel = 3'd6;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL busy_ignore c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] eo [1:8];
      logic       eb [1:8];
      logic       ed [1:8];
      eo = '{8'hF7, 8'hF7, 8'hFF, 8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF};
      eb = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      sel = 3'd3; pulse_len = 4'd2; scan = 1'b0; start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         // Hold start across the first done, then drop it in the second one.
         if (c == 6) start = 1'b0;
         vec_count++;
         if (out_n !== eo[c] || busy !== eb[c] || done !== ed[c]) begin
            err_count++;
            $display("FAIL back_to_back c%0d: out_n=%h busy=%b done=%b want %h/%b/%b",
                     c, out_n, busy, done, eo[c], eb[c], ed[c]);
         end
      end
   endtask

`ifdef SELECT_STROBE_ABORT_EN
   task automatic test_abort();
      sel = 3'd5; pulse_len = 4'd2; scan = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      vec_count++;
      if (out_n !== 8'hDF || busy !== 1'b1) begin
         err_count++;
         $display("FAIL abort_pre: out_n=%h busy=%b want DF/1", out_n, busy);
      end
      tick();
      abort = 1'b0;
      vec_count++;
      if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
         err_count++;
         $display("FAIL abort_c3: out_n=%h busy=%b done=%b want FF/0/0", out_n, busy, done);
      end
      for (int c = 4; c <= 12; c++) begin
         tick();
         vec_count++;
         if (out_n !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
            err_count++;
            $display("FAIL abort_after c%0d: out_n=%h busy=%b done=%b want FF/0/0",
                     c, out_n, busy, done);
         end
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; start = 1'b0; sel = '0; pulse_len = '0; scan = 1'b0;
`ifdef SELECT_STROBE_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_single();
      test_zero_len();
      test_scan();
      test_scan_last();
      test_busy_ignore();
      test_back_to_back();
`ifdef SELECT_STROBE_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule : tb_select_strobe
